dmem_gpio_slave: RTL and testbench

Data-side responder for the pipelined core's MEM-stage bus. It answers core read/write strobes with a word-addressed data RAM and a memory-mapped peripheral page. The peripheral page holds GPIO output, synchronised GPIO input, sticky rising-edge capture and an optional timer. Read data is returned in the same cycle, because the core registers it into MEM/WB on the next CLOCK edge.

---
 rtl/dmem_gpio_pkg.sv | 25 ++
 rtl/dmem_timer.sv | 50 +++++
 rtl/dmem_gpio_slave.sv | 121 ++++++++++++
 tb/tb_dmem_gpio_slave.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmem_gpio_pkg.sv
// rtl/dmem_gpio_pkg.sv - region codes, peripheral offsets and address decode for dmem_gpio_slave
package dmem_gpio_pkg;

  localparam logic [3:0] REG_RAM    = 4'h0;
  localparam logic [3:0] REG_PERIPH = 4'h1;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h04;
  localparam logic [7:0] OFF_EDGE     = 8'h08;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h0C;
  localparam logic [7:0] OFF_TMR_CNT  = 8'h10;
  localparam logic [7:0] OFF_TMR_CMP  = 8'h14;
  localparam logic [7:0] OFF_TMR_STAT = 8'h18;

  typedef enum logic [1:0] {DEC_RAM, DEC_PERIPH, DEC_NONE} dec_t;

  function automatic dec_t decode_region(input logic [3:0] region);
    case (region)
      REG_RAM:    return DEC_RAM;
      REG_PERIPH: return DEC_PERIPH;
      default:    return DEC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - prescaled 32-bit counter with compare and sticky match flag
// Instantiated only when DMEM_TIMER_EN is defined.
module dmem_timer #(
  parameter int TMR_PRESC = 1
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        stat_clr,
  input  logic [31:0] wdata,
  output logic [31:0] cnt,
  output logic [31:0] cmp,
  output logic        match
);

  localparam int PW = (TMR_PRESC > 1) ? $clog2(TMR_PRESC) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [31:0]   cnt_inc;
  logic          match_set;

  assign tick      = (presc == PW'(TMR_PRESC - 1));
  assign cnt_inc   = cnt + 32'd1;
  assign match_set = tick && !cnt_we && (cnt_inc == cmp);

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      presc <= '0;
      cnt   <= 32'd0;
      cmp   <= 32'hFFFF_FFFF;
      match <= 1'b0;
    end else begin
      if (cnt_we) begin
        cnt   <= wdata;
        presc <= '0;
      end else if (tick) begin
        cnt   <= cnt_inc;
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
      if (cmp_we) cmp <= wdata;
      // A match in the same cycle as a clear still leaves the flag set
      match <= (match & ~stat_clr) | match_set;
    end
  end

endmodule

// File: rtl/dmem_gpio_slave.sv
// rtl/dmem_gpio_slave.sv - MEM-stage data RAM and GPIO peripheral page with same-cycle read data
// Optional timer registers are built when DMEM_TIMER_EN is defined.
module dmem_gpio_slave
  import dmem_gpio_pkg::*;
#(
  parameter int RAM_WORDS = 1024,
  parameter int GPIO_W    = 8,
  parameter int TMR_PRESC = 1
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              ena_wr,
  input  logic              ena_rd,
  output logic [31:0]       rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq,
  output logic              bus_err
);

  localparam int RAW = $clog2(RAM_WORDS);

  logic [31:0]       mem [RAM_WORDS];
  logic [GPIO_W-1:0] s1, s2, s3, edge_q, edge_clr;
  logic [1:0]        irq_en;
  logic [31:0]       tmr_cnt, tmr_cmp;
  logic              tmr_match;
  logic              has_tmr;

  dec_t        dec;
  logic [7:0]  off;
  logic [RAW-1:0] idx;
  logic        misaligned, off_valid, access_ok, wr_ok, ram_we, periph_we;
  logic [31:0] periph_rdata;
  logic        unused_addr;

  assign dec         = decode_region(addr[31:28]);
  assign off         = addr[7:0];
  assign idx         = addr[RAW+1:2];
  assign misaligned  = (addr[1:0] != 2'b00);
  assign unused_addr = ^addr[27:RAW+2];

`ifdef DMEM_TIMER_EN
  assign has_tmr = 1'b1;
  dmem_timer #(.TMR_PRESC(TMR_PRESC)) u_timer (
    .CLOCK    (CLOCK),
    .RST_n    (RST_n),
    .cnt_we   (periph_we && off == OFF_TMR_CNT),
    .cmp_we   (periph_we && off == OFF_TMR_CMP),
    .stat_clr (periph_we && off == OFF_TMR_STAT && wdata[0]),
    .wdata    (wdata),
    .cnt      (tmr_cnt),
    .cmp      (tmr_cmp),
    .match    (tmr_match)
  );
`else
  assign has_tmr   = 1'b0;
  assign tmr_cnt   = 32'd0;
  assign tmr_cmp   = 32'd0;
  assign tmr_match = 1'b0;
`endif

  always_comb begin
    off_valid    = 1'b1;
    periph_rdata = 32'd0;
    case (off)
      OFF_GPIO_OUT: periph_rdata = 32'(gpio_out);
      OFF_GPIO_IN:  periph_rdata = 32'(s2);
      OFF_EDGE:     periph_rdata = 32'(edge_q);
      OFF_IRQ_EN:   periph_rdata = 32'(irq_en);
`ifdef DMEM_TIMER_EN
      OFF_TMR_CNT:  periph_rdata = tmr_cnt;
      OFF_TMR_CMP:  periph_rdata = tmr_cmp;
      OFF_TMR_STAT: periph_rdata = 32'(tmr_match);
`endif
      default:      off_valid = 1'b0;
    endcase
  end

  assign access_ok = !misaligned && (dec == DEC_RAM || (dec == DEC_PERIPH && off_valid));
  assign wr_ok     = ena_wr && access_ok;
  assign ram_we    = wr_ok && dec == DEC_RAM;
  assign periph_we = wr_ok && dec == DEC_PERIPH;
  assign edge_clr  = (periph_we && off == OFF_EDGE) ? wdata[GPIO_W-1:0] : '0;

  always_comb begin
    rdata = 32'd0;
    if (ena_rd && access_ok)
      rdata = (dec == DEC_RAM) ? mem[idx] : periph_rdata;
  end

  assign irq = (irq_en[0] & |edge_q) | (irq_en[1] & tmr_match);

  always_ff @(posedge CLOCK) begin
    if (ram_we) mem[idx] <= wdata;
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      edge_q   <= '0;
      gpio_out <= '0;
      irq_en   <= 2'b00;
      bus_err  <= 1'b0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      s3 <= s2;
      // s1 & ~s2 is what s2 & ~s3 becomes after this edge, so EDGE tracks GPIO_IN latency
      edge_q <= (edge_q & ~edge_clr) | (s1 & ~s2);
      if (periph_we && off == OFF_GPIO_OUT) gpio_out <= wdata[GPIO_W-1:0];
      if (periph_we && off == OFF_IRQ_EN)   irq_en   <= {wdata[1] & has_tmr, wdata[0]};
      if ((ena_rd || ena_wr) && !access_ok) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_gpio_slave.sv
// tb/tb_dmem_gpio_slave.sv - directed self-checking bench for dmem_gpio_slave
module tb_dmem_gpio_slave;

  logic        CLOCK;
  logic        RST_n;
  logic [31:0] addr, wdata, rdata;
  logic        ena_wr, ena_rd;
  logic [7:0]  gpio_in, gpio_out;
  logic        irq, bus_err;
  logic [31:0] d;
  int          checks = 0;
  int          errors = 0;

  dmem_gpio_slave dut (
    .CLOCK    (CLOCK),
    .RST_n    (RST_n),
    .addr     (addr),
    .wdata    (wdata),
    .ena_wr   (ena_wr),
    .ena_rd   (ena_rd),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq),
    .bus_err  (bus_err)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge CLOCK);
    addr = a; wdata = v; ena_wr = 1'b1; ena_rd = 1'b0;
    @(negedge CLOCK);
    ena_wr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge CLOCK);
    addr = a; ena_rd = 1'b1; ena_wr = 1'b0;
    #1 v = rdata;
    @(negedge CLOCK);
    ena_rd = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0; addr = 32'd0; wdata = 32'd0; ena_wr = 1'b0; ena_rd = 1'b0; gpio_in = 8'h00;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_rdata_idle", rdata, 32'h0);
    @(negedge CLOCK); RST_n = 1'b1;

    // RAM write/read and aliasing
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0000, 32'h0BAD_F00D);
    rd(32'h0000_0010, d); chk("ram_rd", d, 32'hDEAD_BEEF);
    rd(32'h0000_1010, d); chk("ram_alias", d, 32'hDEAD_BEEF);
    rd(32'h0000_0000, d); chk("ram_word0", d, 32'h0BAD_F00D);

    // Same-cycle read and write return the old value
    @(negedge CLOCK);
    addr = 32'h0000_0010; wdata = 32'h1111_1111; ena_wr = 1'b1; ena_rd = 1'b1;
    #1 chk("ram_rw_old", rdata, 32'hDEAD_BEEF);
    @(negedge CLOCK); ena_wr = 1'b0; ena_rd = 1'b0;
    rd(32'h0000_0010, d); chk("ram_rw_new", d, 32'h1111_1111);

    @(negedge CLOCK);
    addr = 32'h1000_0000; wdata = 32'h0000_00A5; ena_wr = 1'b1; ena_rd = 1'b1;
    #1 chk("gpo_rw_old", rdata, 32'h0);
    @(negedge CLOCK); ena_wr = 1'b0; ena_rd = 1'b0;
    chk("gpio_out", 32'(gpio_out), 32'hA5);
    rd(32'h1000_0000, d); chk("gpo_readback", d, 32'hA5);

    // GPIO input sync, edge capture and irq
    wr(32'h1000_000C, 32'h1);
    rd(32'h1000_000C, d); chk("irq_en_rd", d, 32'h1);
    @(negedge CLOCK);
    gpio_in = 8'h08; addr = 32'h1000_0004; ena_rd = 1'b1;
    @(posedge CLOCK); #1;
    chk("gpi_1edge", rdata, 32'h0);
    chk("irq_1edge", 32'(irq), 32'h0);
    @(posedge CLOCK); #1;
    chk("gpi_2edge", rdata, 32'h08);
    chk("irq_2edge", 32'(irq), 32'h1);
    @(negedge CLOCK); addr = 32'h1000_0008;
    #1 chk("edge_rd", rdata, 32'h08);
    ena_rd = 1'b0;
    wr(32'h1000_0008, 32'h08);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(32'h1000_0008, d); chk("edge_cleared", d, 32'h0);

    // Rise on bit0 coincides with W1C of bit0: set wins
    @(negedge CLOCK); gpio_in = 8'h09;
    @(negedge CLOCK); addr = 32'h1000_0008; wdata = 32'h1; ena_wr = 1'b1;
    @(negedge CLOCK); ena_wr = 1'b0;
    rd(32'h1000_0008, d); chk("edge_set_wins", d, 32'h01);
    chk("irq_set_wins", 32'(irq), 32'h1);
    wr(32'h1000_0008, 32'h1);
    rd(32'h1000_0008, d); chk("edge_clr2", d, 32'h0);

    // Unmapped, reserved and misaligned accesses
    chk("bus_err_clean", 32'(bus_err), 32'h0);
    rd(32'h2000_0000, d); chk("unmapped_rd", d, 32'h0);
    chk("bus_err_set", 32'(bus_err), 32'h1);
    wr(32'h0000_0002, 32'hFFFF_FFFF);
    rd(32'h0000_0000, d); chk("misaligned_wr_dropped", d, 32'h0BAD_F00D);
    rd(32'h0000_0012, d); chk("misaligned_rd", d, 32'h0);
    rd(32'h1000_0020, d); chk("reserved_rd", d, 32'h0);
`ifndef DMEM_TIMER_EN
    rd(32'h1000_0010, d); chk("no_tmr_rd", d, 32'h0);
    wr(32'h1000_000C, 32'h3);
    rd(32'h1000_000C, d); chk("irq_en_bit1_tied", d, 32'h1);
`endif
    repeat (3) @(posedge CLOCK);
    #1 chk("bus_err_sticky", 32'(bus_err), 32'h1);

`ifdef DMEM_TIMER_EN
    wr(32'h1000_0014, 32'd5);
    wr(32'h1000_0010, 32'd0);
    addr = 32'h1000_0018; ena_rd = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge CLOCK); #1 chk("tmr_stat_early", rdata, 32'h0);
    end
    @(posedge CLOCK); #1 chk("tmr_stat_match", rdata, 32'h1);
    ena_rd = 1'b0;
    wr(32'h1000_000C, 32'h2);
    chk("irq_tmr", 32'(irq), 32'h1);
    wr(32'h1000_0018, 32'h1);
    chk("irq_tmr_clr", 32'(irq), 32'h0);
    wr(32'h1000_0010, 32'hFFFF_FFFF);
    addr = 32'h1000_0010; ena_rd = 1'b1;
    #1 chk("tmr_cnt_load", rdata, 32'hFFFF_FFFF);
    @(posedge CLOCK); #1 chk("tmr_cnt_wrap", rdata, 32'h0);
    ena_rd = 1'b0;
`endif

    // Reset during a GPIO_OUT write with an edge flag pending
    wr(32'h1000_000C, 32'h1);
    @(negedge CLOCK); gpio_in = 8'h0B;
    repeat (2) @(posedge CLOCK);
    #1 chk("irq_pre_rst", 32'(irq), 32'h1);
    @(negedge CLOCK);
    addr = 32'h1000_0000; wdata = 32'h0000_003C; ena_wr = 1'b1; gpio_in = 8'h00;
    #2 RST_n = 1'b0;
    #1;
    chk("rst_mid_gpio_out", 32'(gpio_out), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    chk("rst_mid_bus_err", 32'(bus_err), 32'h0);
    @(negedge CLOCK); ena_wr = 1'b0; RST_n = 1'b1;
    chk("rst_write_lost", 32'(gpio_out), 32'h0);
    rd(32'h1000_0008, d); chk("rst_edge", d, 32'h0);
    rd(32'h1000_000C, d); chk("rst_irq_en", d, 32'h0);
`ifdef DMEM_TIMER_EN
    rd(32'h1000_0014, d); chk("rst_tmr_cmp", d, 32'hFFFF_FFFF);
    rd(32'h1000_0018, d); chk("rst_tmr_stat", d, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
